// File: rtl/upload_arb_pkg.sv
// Shared types and constants for the upload arbiter and its round-robin selector.
package upload_arb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    localparam int LEN_W        = 16;
    localparam int MAX_CHANNELS = 16;
    localparam int IDX_W        = $clog2(MAX_CHANNELS);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] value, input logic en);
        if (en && (value != '1)) begin
            return value + LEN_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester scanning upward from i_ptr+1,
// wrapping at N. Reusable by any shared-resource scheduler.
module rr_pick
    import upload_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_pick,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int w_cand;
        // NOTE: every output gets a default before the search so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            for (int i = 0; i < N; i++) begin
                if (!o_any && (i == w_cand) && i_req[i]) begin
                    o_any     = 1'b1;
                    o_pick[i] = 1'b1;
                    o_idx     = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/upload_arbiter.sv
// Frame-level round-robin arbiter merging packed upload channels into one byte stream.
// Optional stall watchdog enabled by defining UPLOAD_ARB_TIMEOUT_EN.
module upload_arbiter
    import upload_arb_pkg::*;
#(
    parameter int          NUM_CHANNELS   = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CHANNELS-1:0]   in_req,
    input  logic [NUM_CHANNELS*8-1:0] in_data,
    input  logic [NUM_CHANNELS*8-1:0] in_source,
    input  logic [NUM_CHANNELS-1:0]   in_valid,
    output logic [NUM_CHANNELS-1:0]   in_ready,
    output logic [7:0]                out_data,
    output logic [7:0]                out_source,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CHANNELS-1:0]   grant,
    output logic                      busy,
    output logic [LEN_W-1:0]          last_frame_len,
    output logic                      timeout_err
);

    arb_state_t              r_state;
    logic [NUM_CHANNELS-1:0] r_grant;
    logic [IDX_W-1:0]        r_g;
    logic [IDX_W-1:0]        r_ptr;
    logic [LEN_W-1:0]        r_byte_cnt;
    logic [LEN_W-1:0]        r_last_len;

    logic [NUM_CHANNELS-1:0] w_pick;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_any;
    logic                    w_req_g;
    logic                    w_valid_g;
    logic                    w_xfer;
    logic                    w_timeout;
    logic                    w_release;

    rr_pick #(
        .N (NUM_CHANNELS)
    ) u_rr_pick (
        .i_req  (in_req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // r_grant is all-zero in IDLE, so the one-hot masks below also blank the outputs.
    assign w_req_g   = |(r_grant & in_req);
    assign w_valid_g = |(r_grant & in_valid);
    assign w_xfer    = w_valid_g & out_ready;
    assign w_release = (r_state == ARB_GRANTED) && (!w_req_g || w_timeout);

    always_comb begin
        out_data   = '0;
        out_source = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (r_grant[i]) begin
                out_data   = in_data[i*8 +: 8];
                out_source = in_source[i*8 +: 8];
            end
        end
    end

    assign in_ready       = r_grant & {NUM_CHANNELS{out_ready}};
    assign out_valid      = w_valid_g;
    assign grant          = r_grant;
    assign busy           = (r_state == ARB_GRANTED);
    assign last_frame_len = r_last_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_g        <= '0;
            r_ptr      <= IDX_W'(NUM_CHANNELS - 1);
            r_byte_cnt <= '0;
            r_last_len <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read in
            // this block sees the pre-edge value regardless of statement order.
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state    <= ARB_GRANTED;
                        r_grant    <= w_pick;
                        r_g        <= w_idx;
                        r_byte_cnt <= '0;
                    end
                end
                ARB_GRANTED: begin
                    r_byte_cnt <= sat_inc(r_byte_cnt, w_xfer);
                    if (w_release) begin
                        r_state    <= ARB_IDLE;
                        r_grant    <= '0;
                        r_ptr      <= r_g;
                        r_last_len <= sat_inc(r_byte_cnt, w_xfer);
                    end
                end
            endcase
        end
    end

`ifdef UPLOAD_ARB_TIMEOUT_EN
    logic [LEN_W-1:0] r_stall_cnt;
    logic             r_timeout_err;
    logic [LEN_W:0]   w_stall_next;

    // Release on the edge where the stall count would reach the limit.
    assign w_stall_next = {1'b0, r_stall_cnt} + (LEN_W + 1)'(1);
    assign w_timeout    = (r_state == ARB_GRANTED) && !w_valid_g
                          && (w_stall_next >= {1'b0, TIMEOUT_CYCLES});
    assign timeout_err  = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if ((r_state != ARB_GRANTED) || w_valid_g) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= w_stall_next[LEN_W-1:0];
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_upload_arbiter.sv
// Self-checking bench for upload_arbiter: directed scenarios plus randomized frame
// traffic compared against a frame-level round-robin model.
module tb_upload_arbiter;

    localparam int N = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_req;
    logic [N*8-1:0] in_data;
    logic [N*8-1:0] in_source;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [7:0]     out_data;
    logic [7:0]     out_source;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [15:0]    last_frame_len;
    logic           timeout_err;

    int n_cmp;
    int n_err;

    // Channel agents: each sends frames of bytes pat(c, frame, index).
    bit a_active [N];
    int a_len    [N];
    int a_sent   [N];
    int a_gap    [N];
    int a_frame  [N];

    // Reference model: granted channel (-1 idle), last served channel, bytes counted.
    int m_g;
    int m_ptr;
    int m_cnt;
    int m_last;

    int k_valid_pct;
    int k_ready_mode;
    int k_min_len;
    int k_max_len;
    int k_drop_pct;
    int k_gap_max;
    bit k_one_shot;
    bit k_enable [N];

    int           n_obs_xfer;
    logic [N-1:0] g_prev;
    logic [N-1:0] q_grant [$];

    upload_arbiter #(
        .NUM_CHANNELS   (N),
        .TIMEOUT_CYCLES (16'd16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_req         (in_req),
        .in_data        (in_data),
        .in_source      (in_source),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_source     (out_source),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .grant          (grant),
        .busy           (busy),
        .last_frame_len (last_frame_len),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] pat(input int c, input int f, input int s);
        return 8'((c * 71 + f * 13 + s * 3 + 5) & 255);
    endfunction

    function automatic logic [7:0] src_id(input int c);
        return 8'(64 + c);
    endfunction

    // First requester after the last served channel, cyclically.
    function automatic int rr_model(input logic [N-1:0] r, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_bench();
        in_req    = '0;
        in_valid  = '0;
        in_data   = '0;
        in_source = '0;
        out_ready = 1'b0;
        for (int c = 0; c < N; c++) begin
            a_active[c] = 1'b0;
            a_len[c]    = 0;
            a_sent[c]   = 0;
            a_gap[c]    = 0;
        end
        m_g    = -1;
        m_ptr  = N - 1;
        m_cnt  = 0;
        m_last = 0;
        g_prev = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_bench();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_knobs(input int vpct, input int rmode, input int lmin, input int lmax,
                             input int dpct, input int gmax, input bit one_shot,
                             input bit en0, input bit en1);
        k_valid_pct  = vpct;
        k_ready_mode = rmode;
        k_min_len    = lmin;
        k_max_len    = lmax;
        k_drop_pct   = dpct;
        k_gap_max    = gmax;
        k_one_shot   = one_shot;
        k_enable[0]  = en0;
        k_enable[1]  = en1;
    endtask

    task automatic traffic(input int cycles);
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        logic         exp_valid;
        int           pick;
        bit           xfer;
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            // NOTE: inputs are driven with blocking assignments half a cycle before
            // the active edge, so the DUT samples settled values.
            case (k_ready_mode)
                0:       out_ready = ($urandom_range(0, 99) < 70);
                1:       out_ready = 1'b1;
                default: out_ready = ~out_ready;
            endcase
            for (int c = 0; c < N; c++) begin
                if (!a_active[c]) begin
                    if (a_gap[c] > 0) begin
                        a_gap[c]--;
                    end else if (k_enable[c]) begin
                        a_active[c] = 1'b1;
                        a_len[c]    = $urandom_range(k_min_len, k_max_len);
                        a_sent[c]   = 0;
                        a_frame[c]++;
                    end
                end
                in_valid[c]        = a_active[c] && (a_sent[c] < a_len[c])
                                     && ($urandom_range(0, 99) < k_valid_pct);
                in_data[c*8 +: 8]   = pat(c, a_frame[c], a_sent[c]);
                in_source[c*8 +: 8] = src_id(c);
                if (!a_active[c] || (a_sent[c] == a_len[c])) begin
                    in_req[c] = 1'b0;
                end else if (grant[c] && in_valid[c] && out_ready && (a_sent[c] + 1 == a_len[c])
                             && ($urandom_range(0, 99) < k_drop_pct)) begin
                    in_req[c] = 1'b0;
                end else begin
                    in_req[c] = 1'b1;
                end
            end
            #1;
            exp_grant = '0;
            if (m_g >= 0) exp_grant[m_g] = 1'b1;
            exp_ready = exp_grant & {N{out_ready}};
            exp_valid = (m_g >= 0) ? in_valid[m_g] : 1'b0;
            n_cmp++;
            if (grant !== exp_grant) begin
                n_err++;
                $display("FAIL grant t=%0t got %b exp %b", $time, grant, exp_grant);
            end
            n_cmp++;
            if (busy !== (m_g >= 0)) begin
                n_err++;
                $display("FAIL busy t=%0t got %b exp %b", $time, busy, (m_g >= 0));
            end
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_err++;
                $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, exp_ready);
            end
            n_cmp++;
            if (out_valid !== exp_valid) begin
                n_err++;
                $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, exp_valid);
            end
            if (exp_valid) begin
                n_cmp++;
                if (out_data !== pat(m_g, a_frame[m_g], a_sent[m_g])) begin
                    n_err++;
                    $display("FAIL out_data t=%0t got %h exp %h", $time, out_data,
                             pat(m_g, a_frame[m_g], a_sent[m_g]));
                end
                n_cmp++;
                if (out_source !== src_id(m_g)) begin
                    n_err++;
                    $display("FAIL out_source t=%0t got %h exp %h", $time, out_source, src_id(m_g));
                end
            end
            n_cmp++;
            if (last_frame_len !== 16'(m_last)) begin
                n_err++;
                $display("FAIL last_frame_len t=%0t got %0d exp %0d", $time, last_frame_len, m_last);
            end
            if (out_valid && out_ready) n_obs_xfer++;
            if ((grant != '0) && (g_prev == '0)) q_grant.push_back(grant);
            g_prev = grant;

            // Effect of the coming clock edge on the model and the agents.
            xfer = (m_g >= 0) && in_valid[m_g] && out_ready;
            if (m_g < 0) begin
                pick = rr_model(in_req, m_ptr);
                if (pick >= 0) begin
                    m_g   = pick;
                    m_cnt = 0;
                end
            end else begin
                if (xfer) begin
                    m_cnt++;
                    a_sent[m_g]++;
                end
                if (!in_req[m_g]) begin
                    m_last = m_cnt;
                    m_ptr  = m_g;
                    m_g    = -1;
                end
            end
            for (int c = 0; c < N; c++) begin
                if (a_active[c] && !in_req[c]) begin
                    a_active[c] = 1'b0;
                    a_gap[c]    = k_one_shot ? (1 << 30) : int'($urandom_range(0, k_gap_max));
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if ((grant !== '0) || (busy !== 1'b0) || (out_valid !== 1'b0) || (out_data !== 8'h00)
            || (out_source !== 8'h00) || (in_ready !== '0) || (last_frame_len !== 16'h0)
            || (timeout_err !== 1'b0)) begin
            n_err++;
            $display("FAIL %s got grant=%b busy=%b ov=%b od=%h os=%h ir=%b len=%0d to=%b exp all zero",
                     tag, grant, busy, out_valid, out_data, out_source, in_ready,
                     last_frame_len, timeout_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_all_zero("reset_initial");
        set_knobs(100, 1, 8, 12, 0, 0, 1'b0, 1'b1, 1'b1);
        traffic(30);
        for (int i = 0; i < 20; i++) begin
            if ((m_g >= 0) && (a_sent[m_g] > 0)) break;
            traffic(1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_frame");
        clear_bench();
        in_req = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (grant !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release_grant got %b exp 00", grant);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ((grant !== 2'b01) || (busy !== 1'b1)) begin
            n_err++;
            $display("FAIL reset_first_grant got grant=%b busy=%b exp 01/1", grant, busy);
        end
        in_req = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        q_grant.delete();
        set_knobs(100, 1, 6, 6, 0, 0, 1'b0, 1'b1, 1'b1);
        traffic(80);
        n_cmp++;
        if (q_grant.size() < 6) begin
            n_err++;
            $display("FAIL rr_grant_count got %0d exp >=6", q_grant.size());
        end
        for (int i = 0; i < 6 && i < q_grant.size(); i++) begin
            n_cmp++;
            if (q_grant[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL rr_order[%0d] got %b exp %b", i, q_grant[i],
                         (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        n_cmp++;
        if (last_frame_len !== 16'd6) begin
            n_err++;
            $display("FAIL rr_len got %0d exp 6", last_frame_len);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        n_obs_xfer = 0;
        set_knobs(100, 2, 10, 10, 0, 0, 1'b1, 1'b1, 1'b0);
        traffic(40);
        n_cmp++;
        if (n_obs_xfer != 10) begin
            n_err++;
            $display("FAIL bp_transfers got %0d exp 10", n_obs_xfer);
        end
        n_cmp++;
        if (last_frame_len !== 16'd10) begin
            n_err++;
            $display("FAIL bp_len got %0d exp 10", last_frame_len);
        end
    endtask

    task automatic test_late_request();
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_req    = 2'b01;
        in_valid  = 2'b01;
        in_data   = {8'hB0, 8'hA0};
        in_source = {8'h41, 8'h40};
        @(negedge clk);
        #1;
        n_cmp++;
        if (grant !== 2'b01) begin
            n_err++;
            $display("FAIL late_first_grant got %b exp 01", grant);
        end
        @(negedge clk);
        in_req   = 2'b11;
        in_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ((grant !== 2'b01) || (in_ready !== 2'b01) || (out_data !== 8'hA0)) begin
                n_err++;
                $display("FAIL late_hold[%0d] got grant=%b ready=%b data=%h exp 01/01/a0",
                         i, grant, in_ready, out_data);
            end
            @(negedge clk);
        end
        in_req   = 2'b10;
        in_valid = 2'b10;
        #1;
        n_cmp++;
        if (grant !== 2'b01) begin
            n_err++;
            $display("FAIL late_drop_cycle got %b exp 01", grant);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ((grant !== 2'b00) || (in_ready !== 2'b00)) begin
            n_err++;
            $display("FAIL late_gap got grant=%b ready=%b exp 00/00", grant, in_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ((grant !== 2'b10) || (out_data !== 8'hB0) || (out_source !== 8'h41)) begin
            n_err++;
            $display("FAIL late_second_grant got grant=%b data=%h src=%h exp 10/b0/41",
                     grant, out_data, out_source);
        end
        in_req   = '0;
        in_valid = '0;
    endtask

    task automatic test_same_cycle_drop();
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_req   = 2'b01;
        in_valid = 2'b01;
        in_data  = {8'h00, 8'hC0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_data[7:0] = 8'(8'hC0 + i);
            if (i == 2) in_req = 2'b00;
            #1;
            n_cmp++;
            if ((grant !== 2'b01) || (out_valid !== 1'b1) || (out_data !== 8'(8'hC0 + i))
                || (in_ready !== 2'b01)) begin
                n_err++;
                $display("FAIL drop_byte[%0d] got grant=%b ov=%b data=%h ready=%b exp 01/1/%h/01",
                         i, grant, out_valid, out_data, in_ready, 8'(8'hC0 + i));
            end
        end
        @(negedge clk);
        in_valid = 2'b00;
        #1;
        n_cmp++;
        if ((grant !== 2'b00) || (busy !== 1'b0) || (last_frame_len !== 16'd3)) begin
            n_err++;
            $display("FAIL drop_release got grant=%b busy=%b len=%0d exp 00/0/3",
                     grant, busy, last_frame_len);
        end
    endtask

`ifdef UPLOAD_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_req   = 2'b11;
        in_valid = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ((grant !== 2'b01) || (timeout_err !== 1'b0)) begin
                n_err++;
                $display("FAIL wd_stall[%0d] got grant=%b to=%b exp 01/0", i, grant, timeout_err);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ((grant !== 2'b00) || (timeout_err !== 1'b1) || (last_frame_len !== 16'd0)) begin
            n_err++;
            $display("FAIL wd_release got grant=%b to=%b len=%0d exp 00/1/0",
                     grant, timeout_err, last_frame_len);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ((grant !== 2'b10) || (timeout_err !== 1'b0)) begin
            n_err++;
            $display("FAIL wd_next_grant got grant=%b to=%b exp 10/0", grant, timeout_err);
        end
        in_req = '0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        set_knobs(75, 0, 1, 12, 50, 4, 1'b0, 1'b1, 1'b1);
        traffic(3000);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int c = 0; c < N; c++) a_frame[c] = 0;
        rst_n = 1'b0;
        clear_bench();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_late_request();
        test_same_cycle_drop();
`ifdef UPLOAD_ARB_TIMEOUT_EN
        test_watchdog();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/upload_arbiter.md
# upload_arbiter

Frame-level round-robin arbiter that merges the packed protocol streams of several upload packer channels into the single byte stream feeding the host transmitter (USB/UART TX). A channel is granted for a whole frame, from the request rising to the request falling, so header, length, payload and checksum bytes are never interleaved across channels. The block also records the length of each forwarded frame and, optionally, reclaims the output from a stalled channel with a watchdog.

## Interface
Parameters:
- NUM_CHANNELS, 2: number of packed upload channels; legal range 1–16.
- TIMEOUT_CYCLES, 65535: stall watchdog limit in cycles; used only with UPLOAD_ARB_TIMEOUT_EN; 16-bit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_req  in  NUM_CHANNELS  per-channel frame request; high for the duration of a frame.
- in_data  in  NUM_CHANNELS*8  per-channel byte; channel i occupies [i*8+:8].
- in_source  in  NUM_CHANNELS*8  per-channel source ID.
- in_valid  in  NUM_CHANNELS  per-channel byte valid.
- in_ready  out  NUM_CHANNELS  per-channel ready.
- out_data  out  8  merged byte.
- out_source  out  8  source ID of the granted channel.
- out_valid  out  1  merged valid.
- out_ready  in  1  transmitter ready.
- grant  out  NUM_CHANNELS  one-hot current grant; zero when idle.
- busy  out  1  high while any channel is granted.
- last_frame_len  out  16  byte count of the most recently released frame.
- timeout_err  out  1  one-cycle pulse on a watchdog release.

## Operation
- States: IDLE, GRANTED.
- **IDLE**
  - grant=0; all in_ready=0; out_valid=0.
  - If any in_req bit is high, pick the first requesting index scanning upward from ptr+1, with wrap-around.
  - Register the pick into grant and g, clear byte_cnt and stall_cnt, and go to GRANTED.
- **GRANTED**
  - Combinational pass-through: out_data=in_data[g], out_source=in_source[g], out_valid=in_valid[g], in_ready[g]=out_ready. All other in_ready bits are 0.
  - A transfer is out_valid && out_ready.
  - Each transfer increments byte_cnt (16-bit, saturates at 0xFFFF).
  - Release condition: in_req[g]==0 sampled at a clock edge.
  - On release: last_frame_len<=byte_cnt (plus 1 if a transfer occurs in that same cycle), ptr<=g, go to IDLE.
- Requests from non-granted channels are held off, never dropped. They are served in round-robin order afterwards.
- A request that drops while not granted is simply not served. No state is kept for it.
- With a single requester, re-grant happens after exactly one IDLE cycle.

## Timing
- Reset values: grant=0, busy=0, out_valid=0, out_data=0, out_source=0, in_ready=0, last_frame_len=0, timeout_err=0; ptr=NUM_CHANNELS-1, so channel 0 wins first.
- Arbitration latency: a request sampled in IDLE produces grant, busy and a valid pass-through on the following cycle.
- Data path latency: 0 cycles (combinational mux). Ready path latency: 0 cycles.
- Minimum inter-frame gap: 1 IDLE cycle, during which no in_ready is asserted.
- Simultaneous requests: resolved strictly by round-robin from ptr+1; the priority is not fixed.
- in_req[g] falling while in_valid[g]=1 and out_ready=1: that byte is transferred and counted, then the grant is released.
- Asynchronous reset mid-frame: the grant drops immediately and the partial frame is abandoned; the transmitter sees out_valid fall.

## Configuration
- UPLOAD_ARB_TIMEOUT_EN defined:
  - stall_cnt (16-bit) increments each GRANTED cycle with in_valid[g]=0 and clears on any cycle with in_valid[g]=1.
  - When stall_cnt reaches TIMEOUT_CYCLES, force a release: timeout_err pulses for 1 cycle, ptr<=g, last_frame_len<=byte_cnt, go to IDLE.
  - If the stalled channel still holds in_req, it re-competes normally.
- UPLOAD_ARB_TIMEOUT_EN undefined: no stall_cnt; a grant is released only by in_req falling; timeout_err is tied 0.

## Structure
- Shared package upload_arb_pkg:
  - state localparams ARB_IDLE=1'b0, ARB_GRANTED=1'b1;
  - LEN_W=16;
  - MAX_CHANNELS=16.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: one-hot pick, binary index, any.
  - Reusable by other shared-resource schedulers.
- Top level holds the state register, ptr, byte_cnt, the optional stall_cnt and the output muxes.

## Test plan
- Reset: assert rst_n=0 mid-simulation → all outputs 0. After release, in_req=2'b11 → grant=2'b01 one cycle later.
- Round-robin: channels 0 and 1 each repeatedly send 6-byte frames with in_req held → grants alternate 01,10,01,10. Each frame's bytes are contiguous and last_frame_len=6 after every release.
- Backpressure: toggle out_ready 1,0 each cycle during a 10-byte frame → exactly 10 transfers; in_ready[g] mirrors out_ready; bytes in order; non-granted in_ready stays 0.
- Late request: channel 1 requests during channel 0's frame → waits, is granted 2 cycles after in_req[0] falls (1 IDLE cycle, then grant), and is not dropped.
- Same-cycle drop: in_req[g] falls in the cycle of the final byte transfer → byte forwarded, last_frame_len includes it, grant released next edge.
- Watchdog (with UPLOAD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): granted channel holds in_req with in_valid=0 → timeout_err pulses after 16 stalled cycles, and the other pending channel is granted next.
